// File: rtl/if_id_buf_pkg.sv
// Shared defines for the IF/ID instruction buffer: default widths, empty-slot
// payload values and the stall codes issued by the pipeline controller.
package if_id_buf_pkg;

    localparam int unsigned INST_W_DEF    = 32;
    localparam int unsigned ADDR_W_DEF    = 32;
    localparam int unsigned INT_W_DEF     = 8;
    localparam int unsigned Hold_Flag_Bus = 3;

    localparam logic [31:0] INST_NOP = 32'h0000_0001;
    localparam logic [31:0] ZeroWord = '0;
    localparam logic [7:0]  INT_NONE = '0;

    typedef enum logic [Hold_Flag_Bus-1:0] {
        Hold_None = 3'b000,
        Hold_Pc   = 3'b001,
        Hold_If   = 3'b010,
        Hold_Id   = 3'b011
    } hold_e;

    // Any stall code at or above Hold_Id freezes the IF/ID stage.
    function automatic logic hold_id_en(input logic [Hold_Flag_Bus-1:0] flag);
        return flag >= Hold_Id;
    endfunction

endpackage

// File: rtl/if_id_buf_if.sv
// IF/ID buffer bus: upstream fetch handshake, control inputs and head-of-queue
// outputs. The buffer uses the slave modport; its environment uses master.
interface if_id_buf_if
    import if_id_buf_pkg::*;
#(
    parameter int unsigned INST_W = INST_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned INT_W  = INT_W_DEF,
    parameter int unsigned DEPTH  = 2
) ();

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                     in_valid_i;
    logic                     in_ready_o;
    logic [INST_W-1:0]        inst_i;
    logic [ADDR_W-1:0]        inst_addr_i;
    logic [INT_W-1:0]         int_flag_i;
    logic [Hold_Flag_Bus-1:0] hold_flag_i;
    logic                     flush_i;
    logic                     out_valid_o;
    logic                     out_ready_i;
    logic [INST_W-1:0]        inst_o;
    logic [ADDR_W-1:0]        inst_addr_o;
    logic [INT_W-1:0]         int_flag_o;
    logic [CNT_W-1:0]         count_o;

    modport slave (
        input  in_valid_i, inst_i, inst_addr_i, int_flag_i,
        input  hold_flag_i, flush_i, out_ready_i,
        output in_ready_o, out_valid_o, inst_o, inst_addr_o, int_flag_o, count_o
    );

    modport master (
        output in_valid_i, inst_i, inst_addr_i, int_flag_i,
        output hold_flag_i, flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, inst_o, inst_addr_o, int_flag_o, count_o
    );

endinterface

// File: rtl/if_id_buf.sv
// IF/ID pipeline buffer: a DEPTH-entry FIFO between fetch and decode with
// stall (hold) and flush control; no bypass, so a push is visible next cycle.
module if_id_buf
    import if_id_buf_pkg::*;
#(
    parameter int unsigned INST_W = INST_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned INT_W  = INT_W_DEF,
    parameter int unsigned DEPTH  = 2
) (
    input logic       clk,
    input logic       rst,
    if_id_buf_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [INT_W-1:0]  int_flag;
        logic [ADDR_W-1:0] addr;
        logic [INST_W-1:0] inst;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic   in_ready;
    logic   out_valid;
    logic   hold_en;
    logic   push;
    logic   pop;
    entry_t head;

    always_comb begin
        in_ready  = count_q < CNT_W'(DEPTH);
        out_valid = count_q != '0;
        hold_en   = hold_id_en(bus.hold_flag_i);
        push      = bus.in_valid_i && in_ready && !bus.flush_i;
        pop       = out_valid && bus.out_ready_i && !hold_en && !bus.flush_i;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Power-of-two DEPTH lets the pointers wrap by natural overflow.
        if (bus.flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage is unreset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{int_flag: bus.int_flag_i,
                                 addr:     bus.inst_addr_i,
                                 inst:     bus.inst_i};
        end
    end

    always_comb begin
        head = mem_q[rd_ptr_q];
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid;
    assign bus.count_o     = count_q;
    assign bus.inst_o      = out_valid ? head.inst     : INST_W'(INST_NOP);
    assign bus.inst_addr_o = out_valid ? head.addr     : ADDR_W'(ZeroWord);
    assign bus.int_flag_o  = out_valid ? head.int_flag : INT_W'(INT_NONE);

endmodule

// File: tb/tb_if_id_buf.sv
// Bench for if_id_buf: directed vector table, corner-case sequences and a
// randomized run scored against a queue-based model of the buffer.
module tb_if_id_buf;
    import if_id_buf_pkg::*;

    localparam int unsigned DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    if_id_buf_if #(.INST_W(32), .ADDR_W(32), .INT_W(8), .DEPTH(DEPTH)) bus ();

    if_id_buf #(.INST_W(32), .ADDR_W(32), .INT_W(8), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
        logic [7:0]  intf;
    } ent_t;

    typedef struct {
        logic        iv;
        logic [31:0] inst;
        logic [31:0] addr;
        logic [2:0]  hold;
        logic        flush;
        logic        ordy;
        logic [2:0]  e_cnt;
        logic        e_valid;
        logic        e_ready;
        logic [31:0] e_inst;
        logic [31:0] e_addr;
    } vec_t;

    ent_t        q[$];
    logic [31:0] pop_log[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    function automatic ent_t mk(input logic [31:0] i, input logic [31:0] a, input logic [7:0] f);
        ent_t e;
        e.inst = i;
        e.addr = a;
        e.intf = f;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    task automatic drive(input logic iv, input ent_t e, input logic [2:0] hold,
                         input logic flush, input logic ordy);
        bus.in_valid_i  = iv;
        bus.inst_i      = e.inst;
        bus.inst_addr_i = e.addr;
        bus.int_flag_i  = e.intf;
        bus.hold_flag_i = hold;
        bus.flush_i     = flush;
        bus.out_ready_i = ordy;
    endtask

    task automatic idle();
        drive(1'b0, mk(32'h0, 32'h0, 8'h0), 3'b000, 1'b0, 1'b0);
    endtask

    // Model: decide push/pop from occupancy and inputs, then advance one edge.
    task automatic tick();
        bit   m_push, m_pop;
        ent_t e;
        m_push = bus.in_valid_i && (q.size() < DEPTH) && !bus.flush_i;
        m_pop  = (q.size() != 0) && bus.out_ready_i && (bus.hold_flag_i < 3'd3) && !bus.flush_i;
        e = mk(bus.inst_i, bus.inst_addr_i, bus.int_flag_i);
        if (m_pop) pop_log.push_back(bus.inst_o);
        @(posedge clk);
        if (bus.flush_i) q.delete();
        else begin
            if (m_pop)  void'(q.pop_front());
            if (m_push) q.push_back(e);
        end
        #1;
    endtask

    task automatic compare_model(input string tag);
        ent_t exp;
        if (q.size() != 0) exp = q[0];
        else exp = mk(32'h0000_0001, 32'h0, 8'h0);
        check({tag, ".valid"}, bus.out_valid_o, q.size() != 0);
        check({tag, ".ready"}, bus.in_ready_o,  q.size() < DEPTH);
        check({tag, ".count"}, bus.count_o,     q.size());
        check({tag, ".inst"},  bus.inst_o,      exp.inst);
        check({tag, ".addr"},  bus.inst_addr_o, exp.addr);
        check({tag, ".intf"},  bus.int_flag_o,  exp.intf);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        q.delete();
        #10;
        rst = 1'b1;
    endtask

    vec_t tbl[8];
    ent_t it[4];

    initial begin
        rst = 1'b0;
        idle();
        #2;
        compare_model("reset");
        check("reset.inst_nop", bus.inst_o, 32'h0000_0001);
        check("reset.ready", bus.in_ready_o, 1'b1);
        #10;
        rst = 1'b1;

        //        iv  inst          addr          hold  fl ordy cnt v rdy  e_inst        e_addr
        tbl[0] = '{1, 32'h0000_0013, 32'h100, 3'b000, 0, 0, 1, 1, 1, 32'h0000_0013, 32'h100};
        tbl[1] = '{1, 32'h00a0_0093, 32'h104, 3'b000, 0, 0, 2, 1, 0, 32'h0000_0013, 32'h100};
        tbl[2] = '{1, 32'h00b0_0113, 32'h108, 3'b000, 0, 0, 2, 1, 0, 32'h0000_0013, 32'h100};
        tbl[3] = '{0, 32'h0,         32'h0,   3'b011, 0, 1, 2, 1, 0, 32'h0000_0013, 32'h100};
        tbl[4] = '{0, 32'h0,         32'h0,   3'b010, 0, 1, 1, 1, 1, 32'h00a0_0093, 32'h104};
        tbl[5] = '{1, 32'h00b0_0113, 32'h108, 3'b000, 0, 1, 1, 1, 1, 32'h00b0_0113, 32'h108};
        tbl[6] = '{1, 32'h00c0_0193, 32'h10c, 3'b000, 1, 1, 0, 0, 1, 32'h0000_0001, 32'h0};
        tbl[7] = '{1, 32'h00c0_0193, 32'h10c, 3'b000, 0, 0, 1, 1, 1, 32'h00c0_0193, 32'h10c};
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].iv, mk(tbl[i].inst, tbl[i].addr, 8'h0), tbl[i].hold, tbl[i].flush, tbl[i].ordy);
            tick();
            check($sformatf("vec%0d.count", i), bus.count_o,     tbl[i].e_cnt);
            check($sformatf("vec%0d.valid", i), bus.out_valid_o, tbl[i].e_valid);
            check($sformatf("vec%0d.ready", i), bus.in_ready_o,  tbl[i].e_ready);
            check($sformatf("vec%0d.inst", i),  bus.inst_o,      tbl[i].e_inst);
            check($sformatf("vec%0d.addr", i),  bus.inst_addr_o, tbl[i].e_addr);
        end

        // Three pushes into two slots; third waits upstream, drains in order.
        do_reset();
        it[0] = mk(32'h1111_0001, 32'h200, 8'h01);
        it[1] = mk(32'h2222_0002, 32'h204, 8'h02);
        it[2] = mk(32'h3333_0003, 32'h208, 8'h03);
        pop_log.delete();
        begin
            int idx = 0;
            bit acc;
            for (int c = 0; c < 20 && pop_log.size() < 3; c++) begin
                if (idx < 3) drive(1'b1, it[idx], 3'b000, 1'b0, c >= 4);
                else drive(1'b0, it[0], 3'b000, 1'b0, 1'b1);
                acc = (idx < 3) && (q.size() < DEPTH);
                tick();
                if (acc) idx++;
                if (c == 2) check("order.ready_full", bus.in_ready_o, 1'b0);
                compare_model("order");
            end
        end
        check("order.npops", pop_log.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < pop_log.size()) check($sformatf("order.pop%0d", i), pop_log[i], it[i].inst);

        // Full with pop and offered push: slot frees only from the next cycle.
        do_reset();
        it[0] = mk(32'h0000_1001, 32'h300, 8'h00);
        it[1] = mk(32'h0000_1002, 32'h304, 8'h00);
        it[2] = mk(32'h0000_1003, 32'h308, 8'h00);
        it[3] = mk(32'h0000_1004, 32'h30c, 8'h00);
        drive(1'b1, it[0], 3'b000, 1'b0, 1'b0); tick();
        drive(1'b1, it[1], 3'b000, 1'b0, 1'b0); tick();
        pop_log.delete();
        drive(1'b1, it[2], 3'b000, 1'b0, 1'b1); tick();
        check("fullpop.count", bus.count_o, 1);
        drive(1'b1, it[2], 3'b000, 1'b0, 1'b1); tick();
        check("pushpop.count", bus.count_o, 1);
        compare_model("pushpop");
        drive(1'b1, it[3], 3'b000, 1'b0, 1'b1); tick();
        drive(1'b0, it[3], 3'b000, 1'b0, 1'b1); tick();
        check("pushpop.npops", pop_log.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < pop_log.size()) check($sformatf("pushpop.pop%0d", i), pop_log[i], it[i].inst);

        // Hold_Id stalls the head despite out_ready; Hold_If does not.
        do_reset();
        drive(1'b1, it[0], 3'b000, 1'b0, 1'b0); tick();
        drive(1'b1, it[1], 3'b000, 1'b0, 1'b0); tick();
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, it[0], 3'b011, 1'b0, 1'b1);
            tick();
            check($sformatf("hold%0d.inst", c), bus.inst_o, it[0].inst);
            check($sformatf("hold%0d.count", c), bus.count_o, 2);
        end
        drive(1'b0, it[0], 3'b010, 1'b0, 1'b1); tick();
        check("holdif.count", bus.count_o, 1);
        check("holdif.inst", bus.inst_o, it[1].inst);

        // Flush beats a same-cycle push.
        drive(1'b1, it[2], 3'b000, 1'b0, 1'b0); tick();
        check("preflush.count", bus.count_o, 2);
        drive(1'b1, it[3], 3'b000, 1'b1, 1'b1); tick();
        check("flush.count", bus.count_o, 0);
        check("flush.valid", bus.out_valid_o, 1'b0);
        check("flush.inst", bus.inst_o, 32'h0000_0001);
        check("flush.addr", bus.inst_addr_o, 32'h0);
        idle(); tick();
        check("flush.dropped", bus.count_o, 0);

        // Asynchronous reset in the middle of a cycle.
        drive(1'b1, it[0], 3'b000, 1'b0, 1'b0); tick();
        drive(1'b1, it[1], 3'b000, 1'b0, 1'b0); tick();
        #3;
        rst = 1'b0;
        #1;
        q.delete();
        check("arst.valid", bus.out_valid_o, 1'b0);
        check("arst.ready", bus.in_ready_o, 1'b1);
        check("arst.count", bus.count_o, 0);
        check("arst.inst", bus.inst_o, 32'h0000_0001);
        #2;
        rst = 1'b1;
        drive(1'b1, it[3], 3'b000, 1'b0, 1'b0); tick();
        check("arst.resume_count", bus.count_o, 1);
        check("arst.resume_inst", bus.inst_o, it[3].inst);

        // Randomized traffic against the queue model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0,
                  mk($urandom, $urandom, 8'($urandom)),
                  3'($urandom_range(0, 7)),
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 2) != 0);
            tick();
            compare_model($sformatf("rand%0d", c));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
